hilo_ctrl: RTL and testbench
============================

# hilo_ctrl

Sequencing and state block for the multiply/divide result registers of the 54-instruction CPU. It accepts DIV/DIVU/MULT/MULTU/MTHI/MTLO requests from the execute stage and latches operands onto the arithmetic units' inputs. It holds the pipeline for a fixed multi-cycle latency while those combinational units settle, then writes HI/LO. It also serves MFHI/MFLO reads and asserts a stall on any hazard against an in-flight operation.

## Interface
- DIV_LAT, 4: cycles from accept to HI/LO write for DIV/DIVU (multicycle path budget); legal 1–15.
- MUL_LAT, 2: same for MULT/MULTU; legal 1–15.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- op_valid  in  1  request present this cycle.
- op_code  in  3  0=DIV, 1=DIVU, 2=MULT, 3=MULTU, 4=MTHI, 5=MTLO; 6–7 ignored (no accept).
- op_a  in  32  rs operand; MTHI/MTLO write data.
- op_b  in  32  rt operand.
- arith_a, arith_b  out  32  registered operands driving divider and multiplier.
- div_res, divu_res  in  64  {quotient, remainder} from divider.
- mul_res, mulu_res  in  64  {hi, lo} product from multiplier.
- rd_en  in  1  MFHI/MFLO in execute.
- rd_sel  in  1  0=LO, 1=HI.
- rd_data  out  32  combinational read of selected register.
- op_ready  out  1  = ~busy.
- stall  out  1  = busy & (op_valid | rd_en).
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse, the cycle HI/LO first shows the new result.
- div0_flag  out  1  sticky divide-by-zero (only with macro).

## Operation
- States: IDLE, BUSY. Reset → IDLE; HI, LO, arith_a, arith_b, latched opcode, counter, done, div0_flag all 0.
- IDLE, op_valid, opcode 0–3: latch op_a/op_b to arith_a/arith_b, latch opcode; load counter with LAT−1; go BUSY.
- IDLE, op_valid, MTHI/MTLO: write HI/LO directly from op_a at that edge; stay IDLE; no done pulse.
- BUSY: counter decrements each cycle; at count 0 write and go IDLE, set done for the next cycle.
- Write mapping: DIV/DIVU → LO = res[63:32] (quotient), HI = res[31:0] (remainder). MULT/MULTU → HI = res[63:32], LO = res[31:0].
- Requests while BUSY are not accepted; stall holds the pipeline so the request re-presents.
- Arithmetic rules are owned by the divider/multiplier. Divide-by-zero yields q=0, r=0. Signed overflow (0x80000000 / −1) is written as produced, not trapped.

## Timing
- Accept at edge E0 → busy high cycles after E0 through edge E_LAT → HI/LO visible and done=1 in the cycle after E_LAT.
- Back-to-back: a new op may be accepted on the edge after the cycle where busy falls, i.e. the first IDLE cycle.
- rd_en and op_valid in the same IDLE cycle: rd_data returns the pre-op value, op is accepted.
- rd_en during BUSY, including the final BUSY cycle: stall=1; read completes in the first IDLE cycle with the new value.
- arith_a/arith_b stay stable for the full BUSY period and hold afterwards.
- rst_n low mid-operation: immediate abort, IDLE, no write, no done.

## Configuration
- HILO_DIV0_TRAP_EN defined: DIV/DIVU with op_b=0 still takes DIV_LAT cycles but leaves HI/LO unchanged. It sets div0_flag, which stays set until reset. done still pulses.
- Not defined: zero-divisor results (0, 0) are written normally; div0_flag tied 0.

## Structure
- Shared package cpu_pkg: op_code enum (HILO_DIV … HILO_MTLO), state enum, default latency constants.
- One sub-module: hilo_regs (HI/LO storage, write-port mux, read mux). The controller FSM and counter stay in hilo_ctrl.

## Test plan
- DIV op_a=0xFFFFFFF9 (−7), op_b=2 → after 4 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF, done pulse exactly once.
- DIVU 0xFFFFFFFF / 0x10 → LO=0x0FFFFFFF, HI=0x0000000F; busy high exactly DIV_LAT cycles.
- MULT 0xFFFFFFFF × 2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE after MUL_LAT cycles; MULTU same operands → HI=0x00000001, LO=0xFFFFFFFE.
- MTHI 0x12345678 then rd_en rd_sel=1 next cycle → rd_data=0x12345678, stall never asserts.
- DIV issued, then rd_en on every BUSY cycle → stall=1 each BUSY cycle; first IDLE read returns the new LO.
- DIV by 0: without macro HI=LO=0; with HILO_DIV0_TRAP_EN HI/LO keep prior 0xAAAA5555 and div0_flag=1. Separately, rst_n pulsed mid-BUSY → HI=LO=0, busy=0, no done.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the HI/LO sequencing block: request opcodes, controller
// states, register-file write kinds and default multicycle latencies.
package cpu_pkg;

    typedef enum logic [2:0] {
        HILO_DIV   = 3'd0,
        HILO_DIVU  = 3'd1,
        HILO_MULT  = 3'd2,
        HILO_MULTU = 3'd3,
        HILO_MTHI  = 3'd4,
        HILO_MTLO  = 3'd5
    } hilo_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } hilo_state_e;

    typedef enum logic [2:0] {
        WR_NONE = 3'd0,
        WR_HI   = 3'd1,
        WR_LO   = 3'd2,
        WR_DIV  = 3'd3,
        WR_MUL  = 3'd4
    } hilo_wr_e;

    localparam int unsigned HILO_DIV_LAT_DEF = 4;
    localparam int unsigned HILO_MUL_LAT_DEF = 2;
    localparam int unsigned CNT_W            = 4;

    // Opcodes 0-3 go through the divider/multiplier.
    function automatic logic is_arith(input logic [2:0] code);
        return code[2] == 1'b0;
    endfunction

endpackage

// File: rtl/hilo_ctrl_if.sv
// Execute-stage <-> HI/LO controller bus, including the operand/result lines
// to the external combinational divider and multiplier.
interface hilo_ctrl_if;

    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] arith_a;
    logic [31:0] arith_b;
    logic [63:0] div_res;
    logic [63:0] divu_res;
    logic [63:0] mul_res;
    logic [63:0] mulu_res;
    logic        rd_en;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        op_ready;
    logic        stall;
    logic        busy;
    logic        done;
    logic        div0_flag;

    modport master (
        output op_valid, op_code, op_a, op_b,
        output div_res, divu_res, mul_res, mulu_res,
        output rd_en, rd_sel,
        input  arith_a, arith_b, rd_data,
        input  op_ready, stall, busy, done, div0_flag
    );

    modport slave (
        input  op_valid, op_code, op_a, op_b,
        input  div_res, divu_res, mul_res, mulu_res,
        input  rd_en, rd_sel,
        output arith_a, arith_b, rd_data,
        output op_ready, stall, busy, done, div0_flag
    );

endinterface

// File: rtl/hilo_regs.sv
// HI/LO storage: one write port selected by write kind (direct move, divider
// or multiplier layout) and a combinational read mux.
module hilo_regs
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  hilo_wr_e    wr_kind,
    input  logic [31:0] wr_data,
    input  logic [63:0] wr_res,
    input  logic        rd_sel,
    output logic [31:0] rd_data
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        hi_d = hi_q;
        lo_d = lo_q;
        case (wr_kind)
            WR_HI:   hi_d = wr_data;
            WR_LO:   lo_d = wr_data;
            WR_DIV: begin
                lo_d = wr_res[63:32];
                hi_d = wr_res[31:0];
            end
            WR_MUL: begin
                hi_d = wr_res[63:32];
                lo_d = wr_res[31:0];
            end
            default: ;
        endcase
    end

    // NOTE: HI/LO are two plain registers, not a RAM, so they take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep flop updates order-independent.
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign rd_data = rd_sel ? hi_q : lo_q;

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO controller: accepts mul/div/move requests, holds operands for a fixed
// multicycle latency, then commits results. Optional macro: HILO_DIV0_TRAP_EN.
module hilo_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned DIV_LAT = HILO_DIV_LAT_DEF,
    parameter int unsigned MUL_LAT = HILO_MUL_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    hilo_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

    hilo_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    hilo_op_e         op_q, op_d;
    logic [31:0]      arith_a_q, arith_a_d;
    logic [31:0]      arith_b_q, arith_b_d;
    logic             done_q, done_d;
    hilo_wr_e         wr_kind;
    logic [63:0]      wr_res;
    logic             op_is_div;
`ifdef HILO_DIV0_TRAP_EN
    logic             div0_q, div0_d;
`endif

    assign op_is_div = (op_q == HILO_DIV) || (op_q == HILO_DIVU);

    always_comb begin
        case (op_q)
            HILO_DIV:  wr_res = bus.div_res;
            HILO_DIVU: wr_res = bus.divu_res;
            HILO_MULT: wr_res = bus.mul_res;
            default:   wr_res = bus.mulu_res;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        arith_a_d = arith_a_q;
        arith_b_d = arith_b_q;
        done_d    = 1'b0;
        wr_kind   = WR_NONE;
`ifdef HILO_DIV0_TRAP_EN
        div0_d    = div0_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid && is_arith(bus.op_code)) begin
                    arith_a_d = bus.op_a;
                    arith_b_d = bus.op_b;
                    op_d      = hilo_op_e'(bus.op_code);
                    cnt_d     = bus.op_code[1] ? MUL_CNT : DIV_CNT;
                    state_d   = ST_BUSY;
                end else if (bus.op_valid && bus.op_code == HILO_MTHI) begin
                    wr_kind = WR_HI;
                end else if (bus.op_valid && bus.op_code == HILO_MTLO) begin
                    wr_kind = WR_LO;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    wr_kind = op_is_div ? WR_DIV : WR_MUL;
`ifdef HILO_DIV0_TRAP_EN
                    // Trapped divide-by-zero: keep HI/LO, record it stickily.
                    if (op_is_div && arith_b_q == '0) begin
                        wr_kind = WR_NONE;
                        div0_d  = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= HILO_DIV;
            arith_a_q <= '0;
            arith_b_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            arith_a_q <= arith_a_d;
            arith_b_q <= arith_b_d;
            done_q    <= done_d;
        end
    end

`ifdef HILO_DIV0_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div0_q <= 1'b0;
        else        div0_q <= div0_d;
    end
    assign bus.div0_flag = div0_q;
`else
    assign bus.div0_flag = 1'b0;
`endif

    hilo_regs u_regs (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_kind (wr_kind),
        .wr_data (bus.op_a),
        .wr_res  (wr_res),
        .rd_sel  (bus.rd_sel),
        .rd_data (bus.rd_data)
    );

    assign bus.busy     = (state_q == ST_BUSY);
    assign bus.op_ready = ~bus.busy;
    assign bus.stall    = bus.busy & (bus.op_valid | bus.rd_en);
    assign bus.done     = done_q;
    assign bus.arith_a  = arith_a_q;
    assign bus.arith_b  = arith_b_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed bench for hilo_ctrl: a vector table of ops with expected HI/LO and
// latency, plus hand sequences for read stalls, back-to-back, div-by-0, reset.
module tb_hilo_ctrl;

    logic clk;
    logic rst_n;
    hilo_ctrl_if bus ();

    hilo_ctrl #(.DIV_LAT(4), .MUL_LAT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural divider / multiplier driven from the registered operands.
    logic [31:0] ma, mb;
    assign ma = bus.arith_a;
    assign mb = bus.arith_b;
    always_comb begin
        bus.mulu_res = {32'h0, ma} * {32'h0, mb};
        bus.mul_res  = {{32{ma[31]}}, ma} * {{32{mb[31]}}, mb};
        if (mb == 32'h0) begin
            bus.div_res  = 64'h0;
            bus.divu_res = 64'h0;
        end else begin
            bus.divu_res = {ma / mb, ma % mb};
            if (mb == 32'hFFFF_FFFF)
                bus.div_res = {32'h0 - ma, 32'h0};
            else
                bus.div_res = {32'($signed(ma) / $signed(mb)), 32'($signed(ma) % $signed(mb))};
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        bus.rd_sel = 1'b1;
        #1 hi = bus.rd_data;
        bus.rd_sel = 1'b0;
        #1 lo = bus.rd_data;
    endtask

    // Present one request for one cycle; returns 1 ns after the accepting edge.
    task automatic do_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.op_a     = a;
        bus.op_b     = b;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] hi, lo;
        int busy_cnt, done_cnt, stall_cnt, cyc;

        vecs[0] = '{3'd0, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 4};
        vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 4};
        vecs[2] = '{3'd2, 32'hFFFF_FFFF, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
        vecs[3] = '{3'd3, 32'hFFFF_FFFF, 32'h2,         32'h0000_0001, 32'hFFFF_FFFE, 2};
        vecs[4] = '{3'd4, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFE, 0};
        vecs[5] = '{3'd5, 32'hCAFE_F00D, 32'h0,         32'h1234_5678, 32'hCAFE_F00D, 0};
        vecs[6] = '{3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 4};
        vecs[7] = '{3'd6, 32'h5555_5555, 32'h1,         32'h0000_0000, 32'h8000_0000, 0};
        vecs[8] = '{3'd1, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 4};

        rst_n        = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_code  = 3'd0;
        bus.op_a     = 32'h0;
        bus.op_b     = 32'h0;
        bus.rd_en    = 1'b0;
        bus.rd_sel   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_busy",     bus.busy,      1'b0);
        check("rst_op_ready", bus.op_ready,  1'b1);
        check("rst_done",     bus.done,      1'b0);
        check("rst_stall",    bus.stall,     1'b0);
        check("rst_arith_a",  bus.arith_a,   32'h0);
        check("rst_arith_b",  bus.arith_b,   32'h0);
        check("rst_div0",     bus.div0_flag, 1'b0);
        read_hilo(hi, lo);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);

        // Vector table: latency, single done pulse, result visible with done
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].code, vecs[i].a, vecs[i].b);
            busy_cnt = 0;
            done_cnt = 0;
            for (int c = 0; c < 12; c++) begin
                if (bus.busy) busy_cnt++;
                if (bus.done) begin
                    done_cnt++;
                    read_hilo(hi, lo);
                    check($sformatf("v%0d_lo_at_done", i), lo, vecs[i].exp_lo);
                end
                @(posedge clk);
                #1;
            end
            check($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].lat);
            check($sformatf("v%0d_done_pulses", i), done_cnt, (vecs[i].lat > 0) ? 1 : 0);
            read_hilo(hi, lo);
            check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
        end

        // MTHI then immediate MFHI: no stall
        do_op(3'd4, 32'h1234_5678, 32'h0);
        check("mthi_stall_accept", bus.stall, 1'b0);
        bus.rd_en  = 1'b1;
        bus.rd_sel = 1'b1;
        #1;
        check("mthi_read",       bus.rd_data, 32'h1234_5678);
        check("mthi_read_stall", bus.stall,   1'b0);
        @(posedge clk);
        #1 bus.rd_en = 1'b0;

        // Read during every BUSY cycle stalls; first IDLE read sees new LO
        do_op(3'd1, 32'd1000, 32'd10);
        bus.rd_en  = 1'b1;
        bus.rd_sel = 1'b0;
        busy_cnt  = 0;
        stall_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (!bus.busy) break;
            busy_cnt++;
            if (bus.stall) stall_cnt++;
            if (bus.arith_a != 32'd1000) check("arith_a_stable", bus.arith_a, 32'd1000);
            @(posedge clk);
            #1;
        end
        check("rdbusy_busy_cycles", busy_cnt, 4);
        check("rdbusy_stall_cycles", stall_cnt, 4);
        check("rdbusy_idle_stall", bus.stall, 1'b0);
        check("rdbusy_idle_data", bus.rd_data, 32'd100);

        // Same first IDLE cycle: new op with read; read sees pre-op LO
        bus.op_valid = 1'b1;
        bus.op_code  = 3'd3;
        bus.op_a     = 32'd3;
        bus.op_b     = 32'd5;
        #1;
        check("b2b_ready",     bus.op_ready, 1'b1);
        check("b2b_stall",     bus.stall,    1'b0);
        check("b2b_read_prev", bus.rd_data,  32'd100);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.rd_en    = 1'b0;
        check("b2b_busy",    bus.busy,    1'b1);
        check("b2b_arith_a", bus.arith_a, 32'd3);
        check("b2b_arith_b", bus.arith_b, 32'd5);
        cyc = 0;
        while (bus.busy && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("b2b_cycles", cyc, 2);
        read_hilo(hi, lo);
        check("b2b_hi", hi, 32'h0);
        check("b2b_lo", lo, 32'd15);
        check("arith_a_hold", bus.arith_a, 32'd3);

        // Divide by zero
        do_op(3'd4, 32'hAAAA_5555, 32'h0);
        do_op(3'd5, 32'hAAAA_5555, 32'h0);
        do_op(3'd0, 32'h0000_1234, 32'h0);
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) done_cnt++;
            @(posedge clk);
            #1;
        end
        check("div0_busy_cycles", busy_cnt, 4);
        check("div0_done_pulses", done_cnt, 1);
        read_hilo(hi, lo);
`ifdef HILO_DIV0_TRAP_EN
        check("div0_hi",   hi, 32'hAAAA_5555);
        check("div0_lo",   lo, 32'hAAAA_5555);
        check("div0_flag", bus.div0_flag, 1'b1);
`else
        check("div0_hi",   hi, 32'h0);
        check("div0_lo",   lo, 32'h0);
        check("div0_flag", bus.div0_flag, 1'b0);
`endif

        // Reset mid-operation: abort, no write, no done
        do_op(3'd2, 32'd7, 32'd9);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        #2 rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_busy_after", bus.busy, 1'b0);
        check("abort_arith_a", bus.arith_a, 32'h0);
        check("abort_div0", bus.div0_flag, 1'b0);
        read_hilo(hi, lo);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
